// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: shadowed hex value, one digit per slot,
// anti-ghost dead time, decimal points, blanking and leading-zero suppression.
module seg7_scan_driver #(
    parameter int NDIG    = 8,
    parameter int DIV_CNT = 100000,
    parameter int DEAD    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   blank_in,
    input  logic              lz_en,
    input  logic              load,
    output logic [NDIG-1:0]   an,
    output logic [7:0]        seg,
    output logic              frame_tick
);

    localparam int PRW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam int PW  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PRW-1:0] PRE_LAST = PRW'(DIV_CNT - 1);
    localparam logic [PRW-1:0] DEAD_V   = PRW'(DEAD);
    localparam logic [PW-1:0]  PTR_LAST = PW'(NDIG - 1);

    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   blank_q, blank_d;
    logic              lz_q, lz_d;
    logic [PRW-1:0]    pre_q, pre_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic              ft_q, ft_d;

    logic              wrap;
    logic              lit;
    logic              zero_run;
    logic [NDIG-1:0]   lz_mask;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic              cur_lz;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        lz_d    = lz_q;
        if (load) begin
            value_d = value;
            dp_d    = dp_in;
            blank_d = blank_in;
            lz_d    = lz_en;
        end

        wrap  = (pre_q == PRE_LAST);
        pre_d = wrap ? '0 : pre_q + 1'b1;
        ptr_d = ptr_q;
        if (wrap) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
        ft_d = wrap && (ptr_q == PTR_LAST);

        // lz_mask[i] set when every nibble from the top down to i is zero
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_run   = zero_run & (value_q[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end

        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (PW'(i) == ptr_q) begin
                cur_nib   = value_q[4*i +: 4];
                cur_dp    = dp_q[i];
                cur_blank = blank_q[i];
                cur_lz    = lz_mask[i];
            end
        end

        lit   = (pre_q >= DEAD_V);
        an_d  = '1;
        seg_d = 8'hFF;
        if (lit) begin
            for (int i = 0; i < NDIG; i++) begin
                if (PW'(i) == ptr_q) an_d[i] = 1'b0;
            end
            if (!cur_blank) begin
                seg_d = {~cur_dp, (lz_q && cur_lz) ? 7'h7F : dec7(cur_nib)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            lz_q    <= 1'b0;
            pre_q   <= '0;
            ptr_q   <= '0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
            ft_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            lz_q    <= lz_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            ft_q    <= ft_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a driver pushes expected outputs from an
// arithmetic scan model, a monitor pops and compares after each rising edge.
module tb_seg7_scan_driver;

    localparam int ND   = 4;
    localparam int DIV  = 4;
    localparam int DT   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          lz_en = 1'b0;
    logic          load = 1'b0;
    logic [3:0]    an;
    logic [7:0]    seg;
    logic          frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model state: shadow copy and number of edges since reset release
    logic [15:0] sh_val = '0;
    logic [3:0]  sh_dp = '0;
    logic [3:0]  sh_bl = '0;
    logic        sh_lz = 1'b0;
    int          edges = 0;

    logic [12:0] exp_q [$];

    seg7_scan_driver #(.NDIG(ND), .DIV_CNT(DIV), .DEAD(DT)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_in(blank_in),
        .lz_en(lz_en), .load(load), .an(an), .seg(seg), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Output seen after an edge reflects the scan position reached after e earlier edges.
    function automatic logic [12:0] model(input int e);
        int         pre, d;
        logic [3:0] an_e, nib;
        logic [7:0] seg_e;
        logic       ft, supp;
        pre   = e % DIV;
        d     = (e / DIV) % ND;
        ft    = ((e + 1) % (DIV * ND)) == 0;
        an_e  = 4'hF;
        seg_e = 8'hFF;
        if (pre >= DT) begin
            an_e[d] = 1'b0;
            if (!sh_bl[d]) begin
                nib   = 4'((sh_val >> (4 * d)) & 16'hF);
                supp  = sh_lz && (d > 0) && ((sh_val >> (4 * d)) == 16'd0);
                seg_e = {~sh_dp[d], supp ? 7'h7F : dec_tab[nib]};
            end
        end
        return {ft, an_e, seg_e};
    endfunction

    task automatic cyc(input logic rst, input logic ld, input logic [15:0] v,
                       input logic [3:0] dp, input logic [3:0] bl, input logic lz);
        @(negedge clk);
        rst_n    = rst;
        load     = ld;
        value    = v;
        dp_in    = dp;
        blank_in = bl;
        lz_en    = lz;
        if (!rst) begin
            sh_val = '0; sh_dp = '0; sh_bl = '0; sh_lz = 1'b0;
            edges  = 0;
            exp_q.push_back({1'b0, 4'hF, 8'hFF});
        end else begin
            exp_q.push_back(model(edges));
            if (ld) begin
                sh_val = v; sh_dp = dp; sh_bl = bl; sh_lz = lz;
            end
            edges++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    initial begin : monitor
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an", {4'h0, an}, {4'h0, e[11:8]});
                check("seg", seg, e[7:0]);
                check("frame_tick", {7'h0, frame_tick}, {7'h0, e[12]});
                check("an_onehot_low", 8'($countones(~an) <= 1), 8'd1);
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(8);
        cyc(1'b1, 1'b1, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
        idle(34);
        cyc(1'b1, 1'b1, 16'h0050, 4'b0000, 4'b0000, 1'b1);
        idle(20);
        cyc(1'b1, 1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        idle(20);
        cyc(1'b1, 1'b1, 16'h8888, 4'b0100, 4'b0001, 1'b0);
        idle(20);
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 1'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        for (int i = 0; i < 200; i++)
            cyc(1'b1, ($urandom_range(0, 9) == 0), 16'($urandom_range(0, 255) << (4 * $urandom_range(0, 2))),
                4'($urandom), 4'($urandom_range(0, 1)), 1'($urandom));

        cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
        cyc(1'b1, 1'b1, 16'h3210, 4'b1111, 4'b0000, 1'b0);
        idle(9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_an", {4'h0, an}, 8'h0F);
        check("async_reset_seg", seg, 8'hFF);
        check("async_reset_ft", {7'h0, frame_tick}, 8'h00);
        sh_val = '0; sh_dp = '0; sh_bl = '0; sh_lz = 1'b0;
        edges  = 0;
        cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(12);

        @(posedge clk);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
